// File: rtl/demux_rr_scheduler.sv
// Round-robin scheduler that lends a 1-to-4 bit demultiplexer to four requesters
// for fixed-length, non-preemptive bursts taken from a single serial source.
module demux_rr_scheduler #(
    parameter int BURST_LEN = 4,
    parameter int CNT_W     = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [3:0] i_req,
    input  logic       i_src_valid,
    input  logic       i_src_bit,
    output logic       o_src_ready,
    output logic [1:0] o_dec_select,
    output logic       o_dec_in,
    output logic [3:0] o_grant,
    output logic       o_busy,
    output logic       o_done
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

    state_t           r_state;
    logic [1:0]       r_ptr;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_grant;
    logic [1:0]       r_sel;
    logic             r_din;
    logic             r_done;

    logic             w_found;
    logic [1:0]       w_winner;
    logic [1:0]       w_idx;

    // Rotating priority search: scanning from the farthest offset down lets
    // the closest set bit to r_ptr overwrite the others and win.
    always_comb begin
        // NOTE: every comb output gets a default first so no latch is inferred.
        w_found  = 1'b0;
        w_winner = r_ptr;
        w_idx    = r_ptr;
        for (int k = 3; k >= 0; k--) begin
            w_idx = r_ptr + 2'(k);
            if (i_req[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        // NOTE: state is updated with non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_ptr   <= 2'd0;
            r_cnt   <= '0;
            r_grant <= 4'd0;
            r_sel   <= 2'd0;
            r_din   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_din <= 1'b0;
                    r_cnt <= '0;
                    if (w_found) begin
                        r_grant <= 4'b0001 << w_winner;
                        r_sel   <= w_winner;
                        r_state <= ST_XFER;
                    end else begin
                        r_grant <= 4'd0;
                    end
                end
                ST_XFER: begin
                    if (i_src_valid) begin
                        r_din <= i_src_bit;
                        if (r_cnt == LAST_BEAT) begin
                            // grant/select stay put through the done cycle so
                            // the last bit lands on the owner's output.
                            r_state <= ST_IDLE;
                            r_done  <= 1'b1;
                            r_ptr   <= r_sel + 2'd1;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end else begin
                        r_din <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign o_src_ready  = (r_state == ST_XFER);
    assign o_busy       = (r_state == ST_XFER);
    assign o_grant      = r_grant;
    assign o_dec_select = r_sel;
    assign o_dec_in     = r_din;
    assign o_done       = r_done;

endmodule

// File: tb/tb_demux_rr_scheduler.sv
// Directed bench for demux_rr_scheduler: a vector table for the basic burst
// plus hand-written sequences for rotation, stalls, request drop and reset.
module tb_demux_rr_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       src_valid;
    logic       src_bit;

    logic       a_ready, a_din, a_busy, a_done;
    logic [1:0] a_sel;
    logic [3:0] a_grant;
    logic       b_ready, b_din, b_busy, b_done;
    logic [1:0] b_sel;
    logic [3:0] b_grant;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    demux_rr_scheduler #(.BURST_LEN(4)) dut (
        .i_clk(clk), .i_rst(rst), .i_req(req),
        .i_src_valid(src_valid), .i_src_bit(src_bit),
        .o_src_ready(a_ready), .o_dec_select(a_sel), .o_dec_in(a_din),
        .o_grant(a_grant), .o_busy(a_busy), .o_done(a_done)
    );

    demux_rr_scheduler #(.BURST_LEN(1)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_req(req),
        .i_src_valid(src_valid), .i_src_bit(src_bit),
        .o_src_ready(b_ready), .o_dec_select(b_sel), .o_dec_in(b_din),
        .o_grant(b_grant), .o_busy(b_busy), .o_done(b_done)
    );

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       v;
        logic       b;
        logic [3:0] e_grant;
        logic [1:0] e_sel;
        logic       e_din;
        logic       e_busy;
        logic       e_done;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        src_valid = 1'b0;
        src_bit = 1'b0;
        req = 4'd0;
        tick();
        rst = 1'b0;
    endtask

    logic [3:0] grants[5];
    int         n_grants;
    int         n_done;
    int         n_busy;
    logic       prev_busy;
    logic [3:0] e_g1;

    initial begin
        rst = 1'b1; req = 4'd0; src_valid = 1'b0; src_bit = 1'b0;
        tick();
        tick();
        check("rst_grant",  32'(a_grant), 32'h0);
        check("rst_sel",    32'(a_sel),   32'h0);
        check("rst_din",    32'(a_din),   32'h0);
        check("rst_ready",  32'(a_ready), 32'h0);
        check("rst_busy",   32'(a_busy),  32'h0);
        check("rst_done",   32'(a_done),  32'h0);
        rst = 1'b0;

        // Single requester 1, stream 1,0,1,1; then re-grant, then reset.
        vecs[0] = '{1'b0, 4'b0010, 1'b1, 1'b0, 4'b0010, 2'd1, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{1'b0, 4'b0010, 1'b1, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 4'b0010, 1'b1, 1'b0, 4'b0010, 2'd1, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 4'b0010, 1'b1, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 4'b0010, 1'b1, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b0, 1'b1};
        vecs[5] = '{1'b0, 4'b0010, 1'b1, 1'b0, 4'b0010, 2'd1, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{1'b1, 4'b0010, 1'b1, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 8; i++) begin
            rst = vecs[i].rst; req = vecs[i].req;
            src_valid = vecs[i].v; src_bit = vecs[i].b;
            tick();
            check($sformatf("vec%0d_grant", i), 32'(a_grant), 32'(vecs[i].e_grant));
            check($sformatf("vec%0d_sel", i),   32'(a_sel),   32'(vecs[i].e_sel));
            check($sformatf("vec%0d_din", i),   32'(a_din),   32'(vecs[i].e_din));
            check($sformatf("vec%0d_busy", i),  32'(a_busy),  32'(vecs[i].e_busy));
            check($sformatf("vec%0d_ready", i), 32'(a_ready), 32'(vecs[i].e_busy));
            check($sformatf("vec%0d_done", i),  32'(a_done),  32'(vecs[i].e_done));
        end

        // All requesting: rotation order and done count in first 20 cycles.
        do_reset();
        req = 4'b1111; src_valid = 1'b1; src_bit = 1'b1;
        n_grants = 0; n_done = 0; prev_busy = 1'b0;
        for (int t = 1; t <= 30; t++) begin
            tick();
            if (a_busy && !prev_busy && n_grants < 5) begin
                grants[n_grants] = a_grant;
                n_grants++;
            end
            if (t <= 20 && a_done) n_done++;
            check("inv_onehot0", 32'($onehot0(a_grant)), 32'h1);
            check("inv_busy_grant", 32'(a_busy && (a_grant == 4'd0)), 32'h0);
            check("inv_done_busy", 32'(a_busy && a_done), 32'h0);
            prev_busy = a_busy;
        end
        check("rr_grant0", 32'(grants[0]), 32'b0001);
        check("rr_grant1", 32'(grants[1]), 32'b0010);
        check("rr_grant2", 32'(grants[2]), 32'b0100);
        check("rr_grant3", 32'(grants[3]), 32'b1000);
        check("rr_grant4", 32'(grants[4]), 32'b0001);
        check("rr_done_count", 32'(n_done), 32'd4);

        // Stalls: valid toggles during a burst to destination 2.
        do_reset();
        req = 4'b0100;
        tick();
        check("stall_grant", 32'(a_grant), 32'b0100);
        n_busy = a_busy ? 1 : 0;
        n_done = 0;
        for (int k = 0; k < 20; k++) begin
            src_valid = (k % 2 == 0);
            src_bit = 1'b1;
            tick();
            check($sformatf("stall_din%0d", k), 32'(a_din), 32'(src_valid));
            check($sformatf("stall_sel%0d", k), 32'(a_sel), 32'd2);
            if (a_busy) n_busy++;
            if (a_done) begin
                n_done++;
                break;
            end
        end
        check("stall_xfer_len", 32'(n_busy), 32'd7);
        check("stall_done_count", 32'(n_done), 32'd1);
        tick();
        check("stall_done_pulse", 32'(a_done), 32'h0);

        // Owner drops request mid-burst; next winner is 3, not 0.
        do_reset();
        req = 4'b1001; src_valid = 1'b1; src_bit = 1'b1;
        tick();
        check("drop_grant0", 32'(a_grant), 32'b0001);
        tick();
        req = 4'b0000;
        tick();
        tick();
        check("drop_still_busy", 32'(a_busy), 32'h1);
        check("drop_still_grant", 32'(a_grant), 32'b0001);
        req = 4'b1001;
        tick();
        check("drop_done", 32'(a_done), 32'h1);
        check("drop_done_grant", 32'(a_grant), 32'b0001);
        tick();
        check("drop_next_grant", 32'(a_grant), 32'b1000);
        check("drop_next_sel", 32'(a_sel), 32'd3);

        // Reset during beat 2 of a burst to destination 3.
        do_reset();
        req = 4'b1000; src_valid = 1'b1; src_bit = 1'b1;
        tick();
        check("rstmid_grant", 32'(a_grant), 32'b1000);
        tick();
        tick();
        check("rstmid_din", 32'(a_din), 32'h1);
        rst = 1'b1;
        tick();
        check("rstmid_grant0", 32'(a_grant), 32'h0);
        check("rstmid_busy",   32'(a_busy),  32'h0);
        check("rstmid_done",   32'(a_done),  32'h0);
        check("rstmid_din0",   32'(a_din),   32'h0);
        check("rstmid_sel",    32'(a_sel),   32'h0);
        rst = 1'b0; req = 4'b1010;
        tick();
        check("rstmid_next_grant", 32'(a_grant), 32'b0010);

        // BURST_LEN=1 instance alternating between requesters 0 and 2.
        do_reset();
        req = 4'b0101; src_valid = 1'b1; src_bit = 1'b1;
        for (int t = 1; t <= 6; t++) begin
            tick();
            e_g1 = (((t - 1) / 2) % 2 == 0) ? 4'b0001 : 4'b0100;
            check($sformatf("bl1_grant%0d", t), 32'(b_grant), 32'(e_g1));
            check($sformatf("bl1_busy%0d", t),  32'(b_busy),  32'(t % 2));
            check($sformatf("bl1_done%0d", t),  32'(b_done),  32'((t + 1) % 2));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
